// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial pattern transmitter, its receiver and the benches.
//   state_t    : transmitter FSM state encoding (ST_IDLE, ST_SHIFT, ST_GAP)
//   PAT_101011 : reference pattern the receiver-side detector looks for
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int unsigned PAT_W = 6;
  localparam logic [PAT_W-1:0] PAT_101011 = 6'b101011;

endpackage

// File: rtl/serial_seq_tx_tick.sv
// bit_tick_gen: per-bit cycle counter for the serial transmitter.
//   clk, reset  : system clock, asynchronous active-high reset
//   run         : count while high; counter held at 0 while low
//   end_of_bit  : counter is at DIV-1 (last cycle of a bit time)
//   mid_bit     : counter is at DIV/2 (receiver sampling point)
module bit_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic end_of_bit,
  output logic mid_bit
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cyc_cnt;

  // Free-running 0..DIV-1 while run is high; wraps at each bit boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc_cnt <= '0;
    end else if (!run || end_of_bit) begin
      r_cyc_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
    end
  end

  assign end_of_bit = (r_cyc_cnt == CNT_W'(DIV - 1));
  assign mid_bit    = (r_cyc_cnt == CNT_W'(DIV / 2));

endmodule

// File: rtl/serial_seq_tx.sv
// serial_seq_tx: parallel-in, MSB-first serial transmitter with mid-bit strobe.
//   clk, reset  : system clock, asynchronous active-high reset
//   load_valid  : load_data valid; accepted when load_ready is high
//   load_data   : WIDTH-bit word to send
//   load_ready  : high only while idle
//   repeat_en   : sampled in the final frame cycle; 1 resends the held word back to back
//   dout        : serial data, 0 when idle or in the inter-frame gap
//   bit_stb     : one-cycle pulse at cycle DIV/2 of each data bit
//   busy        : high while shifting or in the gap
//   frame_done  : one-cycle pulse on the first cycle after the last data bit
//   bit_idx     : index of the bit now on dout, 0 when not shifting
module serial_seq_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned DIV      = 4,
  parameter int unsigned GAP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     load_ready,
  input  logic                     repeat_en,
  output logic                     dout,
  output logic                     bit_stb,
  output logic                     busy,
  output logic                     frame_done,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_shift;
  logic [IDX_W-1:0] r_bit_idx;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_busy;
  logic             r_load_ready;
  logic             r_frame_done;

  logic w_end_of_bit;
  logic w_mid_bit;
  logic w_last_bit;
  logic w_last_gap;
  logic w_frame_end;

  // Bit timing runs for the whole frame including the gap, so the gap is
  // measured in the same bit times as the data.
  bit_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .run        (r_busy),
    .end_of_bit (w_end_of_bit),
    .mid_bit    (w_mid_bit)
  );

  assign w_last_bit = (r_bit_idx == '0);
  assign w_last_gap = (r_gap_cnt == GAP_W'(GAP_BITS - 1));

  // Final cycle of the frame: end of the last data bit with no gap, or end of the last gap bit.
  assign w_frame_end = w_end_of_bit &&
                       (((r_state == ST_SHIFT) && w_last_bit && (GAP_BITS == 0)) ||
                        ((r_state == ST_GAP) && w_last_gap));

  // FSM, hold/shift registers and counters. The frame-end block comes last so
  // it overrides the SHIFT/GAP updates with either a reload or a return to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_gap_cnt    <= '0;
      r_busy       <= 1'b0;
      r_load_ready <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_valid && r_load_ready) begin
            r_hold       <= load_data;
            r_shift      <= load_data;
            r_bit_idx    <= IDX_W'(WIDTH - 1);
            r_state      <= ST_SHIFT;
            r_busy       <= 1'b1;
            r_load_ready <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_end_of_bit) begin
            if (!w_last_bit) begin
              r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
              r_bit_idx <= r_bit_idx - IDX_W'(1);
            end else begin
              r_frame_done <= 1'b1;
              r_shift      <= '0;
              r_bit_idx    <= '0;
              if (GAP_BITS != 0) begin
                r_state   <= ST_GAP;
                r_gap_cnt <= '0;
              end
            end
          end
        end
        ST_GAP: begin
          if (w_end_of_bit && !w_last_gap) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_frame_end) begin
        if (repeat_en) begin
          r_state   <= ST_SHIFT;
          r_shift   <= r_hold;
          r_bit_idx <= IDX_W'(WIDTH - 1);
        end else begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_load_ready <= 1'b1;
        end
      end
    end
  end

  assign dout       = r_shift[WIDTH-1];
  assign bit_stb    = (r_state == ST_SHIFT) && w_mid_bit;
  assign busy       = r_busy;
  assign load_ready = r_load_ready;
  assign frame_done = r_frame_done;
  assign bit_idx    = r_bit_idx;

endmodule

// File: tb/tb_serial_seq_tx.sv
// tb_serial_seq_tx: three transmitter instances (DIV/GAP_BITS = 4/1, 4/0, 2/1) checked
// every cycle against a timeline model of the frame, plus directed frame-timing,
// load-while-busy, repeat, loopback-detect and mid-frame reset scenarios.
module tb_serial_seq_tx;
  import serial_pkg::*;

  localparam int W  = 6;
  localparam int NI = 3;

  function automatic int p_div(input int i);
    return (i == 2) ? 2 : 4;
  endfunction

  function automatic int p_gap(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  logic          clk = 1'b0;
  logic          reset;
  logic [NI-1:0] lv;
  logic [NI-1:0] re;
  logic [W-1:0]  ld [NI];
  logic [NI-1:0] lr;
  logic [NI-1:0] dout;
  logic [NI-1:0] stb;
  logic [NI-1:0] busy;
  logic [NI-1:0] fd;
  logic [2:0]    bi [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_seq_tx #(
      .WIDTH    (W),
      .DIV      ((g == 2) ? 2 : 4),
      .GAP_BITS ((g == 1) ? 0 : 1)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (lv[g]),
      .load_data  (ld[g]),
      .load_ready (lr[g]),
      .repeat_en  (re[g]),
      .dout       (dout[g]),
      .bit_stb    (stb[g]),
      .busy       (busy[g]),
      .frame_done (fd[g]),
      .bit_idx    (bi[g])
    );
  end

  // Receiver for loopback on instance 0
  logic [W-1:0] rx_q;
  logic         rx_clr;
  logic         rx_det;
  always @(posedge clk) begin
    if (rx_clr)      rx_q <= '0;
    else if (stb[0]) rx_q <= {rx_q[W-2:0], dout[0]};
  end
  assign rx_det = (rx_q == PAT_101011);

  int n_err    = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: each instance is either idle or at time m_t within a frame of
  // (W+GAP)*DIV cycles; data bit k occupies cycles k*DIV..k*DIV+DIV-1.
  bit           m_active [NI];
  bit           m_done   [NI];
  int           m_t      [NI];
  logic [W-1:0] m_word   [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_active[i] = 0;
      m_done[i]   = 0;
      m_t[i]      = 0;
      m_word[i]   = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      m_done[i] = 0;
      if (!m_active[i]) begin
        if (lv[i]) begin
          m_active[i] = 1;
          m_word[i]   = ld[i];
          m_t[i]      = 0;
        end
      end else begin
        m_t[i]++;
        if (m_t[i] == W * p_div(i)) m_done[i] = 1;
        if (m_t[i] == (W + p_gap(i)) * p_div(i)) begin
          if (re[i]) m_t[i] = 0;
          else       m_active[i] = 0;
        end
      end
    end
  endtask

  function automatic bit in_shift(input int i);
    return m_active[i] && (m_t[i] < W * p_div(i));
  endfunction

  function automatic logic exp_dout(input int i);
    if (!in_shift(i)) return 1'b0;
    return m_word[i][W - 1 - m_t[i] / p_div(i)];
  endfunction

  function automatic logic exp_stb(input int i);
    return in_shift(i) && ((m_t[i] % p_div(i)) == p_div(i) / 2);
  endfunction

  function automatic int exp_idx(input int i);
    return in_shift(i) ? (W - 1 - m_t[i] / p_div(i)) : 0;
  endfunction

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d.load_ready", i), lr[i],   !m_active[i]);
      check($sformatf("u%0d.busy", i),       busy[i], m_active[i]);
      check($sformatf("u%0d.dout", i),       dout[i], exp_dout(i));
      check($sformatf("u%0d.bit_stb", i),    stb[i],  exp_stb(i));
      check($sformatf("u%0d.frame_done", i), fd[i],   m_done[i]);
      check($sformatf("u%0d.bit_idx", i),    bi[i],   exp_idx(i));
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input int i, input logic [W-1:0] word);
    ld[i] = word;
    lv[i] = 1'b1;
    tick();
    lv[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    re[i] = 1'b0;
    for (int k = 0; k < 100 && m_active[i]; k++) tick();
  endtask

  // Cycles until the next frame_done, bounded.
  task automatic measure(input int i, input int exp, input string tag);
    int c = 0;
    do begin
      tick();
      c++;
    end while (!fd[i] && c < 4 * exp);
    check(tag, c, exp);
  endtask

  task automatic loopback(input logic [W-1:0] word, input string tag);
    int n = 0;
    wait_idle(0);
    rx_clr = 1'b1;
    tick();
    rx_clr = 1'b0;
    send(0, word);
    for (int c = 0; c < 32; c++) begin
      check(tag, rx_det, (word == PAT_101011) && (n >= W));
      if (exp_stb(0)) n++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    lv     = '0;
    re     = '0;
    rx_clr = 1'b1;
    for (int i = 0; i < NI; i++) ld[i] = '0;
    model_reset();
    repeat (2) tick();
    reset  = 1'b0;
    rx_clr = 1'b0;
    tick();

    // Single frame, then ready four cycles after frame_done
    send(0, PAT_101011);
    measure(0, 24, "t2_frame_done_cycle");
    begin
      int c = 0;
      do begin
        tick();
        c++;
      end while (!lr[0] && c < 20);
      check("t2_ready_after_done", c, 4);
    end

    // Load attempt with a different word while busy
    send(0, PAT_101011);
    for (int c = 0; c < 28; c++) begin
      lv[0] = (c == 10);
      if (c == 10) ld[0] = '0;
      tick();
    end
    lv[0] = 1'b0;
    wait_idle(0);

    // Continuous repeat with no gap
    re[1] = 1'b1;
    send(1, PAT_101011);
    measure(1, 24, "t4_first_frame");
    measure(1, 24, "t4_period_a");
    measure(1, 24, "t4_period_b");
    re[1] = 1'b0;
    measure(1, 24, "t4_last_frame");
    check("t4_idle_after_stop", lr[1], 1'b1);

    // Loopback into a shift-register detector
    loopback(PAT_101011, "t5_detect_pat");
    loopback(6'b010100, "t5_detect_other");

    // DIV=2 frame length
    send(2, PAT_101011);
    measure(2, 12, "t6_frame_len_div2");
    wait_idle(2);

    // Random traffic on all instances
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NI; i++) begin
        lv[i] = ($urandom_range(0, 3) == 0);
        ld[i] = W'($urandom);
        re[i] = ($urandom_range(0, 2) != 0);
      end
      tick();
    end
    lv = '0;
    for (int i = 0; i < NI; i++) wait_idle(i);

    // Asynchronous reset mid-frame
    for (int i = 0; i < NI; i++) send(i, W'($urandom));
    repeat ($urandom_range(3, 9)) tick();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    tick();
    reset = 1'b0;
    tick();
    send(0, PAT_101011);
    measure(0, 24, "post_reset_frame");
    wait_idle(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
